alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one registered ALU between two requesters (req0, req1) using a valid/ready request/response handshake.
- Round-robin arbitration; one operation in flight at a time.
- Sequences the ALU operand/enable timing and captures the 2×DATA_WIDTH result.
- Returns the result to the originating requester; illegal function codes are rejected without issuing to the ALU.

Parameters:
- DATA_WIDTH, 8, operand width; result width is 2*DATA_WIDTH.
- FUNC_WIDTH, 4, ALU function code width.
- MAX_FUNC, 13, highest legal function code; codes above it are errors.

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  request accepted this cycle
- req0_a, req0_b  in  DATA_WIDTH  operands
- req0_func  in  FUNC_WIDTH  ALU function code
- rsp0_valid  out  1  response available for requester 0
- rsp0_ready  in  1  requester 0 takes the response
- rsp0_data  out  2*DATA_WIDTH  result
- rsp0_err  out  1  illegal function code
- req1_*, rsp1_*  same as requester 0, for requester 1
- alu_a, alu_b  out  DATA_WIDTH  ALU operands
- alu_func  out  FUNC_WIDTH  ALU function code
- alu_enable  out  1  ALU execute strobe
- alu_out  in  2*DATA_WIDTH  ALU result
- alu_out_valid  in  1  ALU result valid
- busy  out  1  state is not IDLE

Behaviour:
- Reset: state IDLE, rr pointer = 0 (req0 favoured). All outputs 0: req*_ready, rsp*_valid, rsp*_data, rsp*_err, alu_a, alu_b, alu_func, alu_enable, busy.
- ALU timing contract:
  - Operands are sampled on the edge after they are presented.
  - alu_func and alu_enable are sampled on the following edge.
  - alu_out_valid is high exactly one cycle, two edges after alu_enable.
- FSM states: IDLE, LOAD, EXEC, WAIT, RESP.
- IDLE:
  - If any req_valid, grant one requester. Pulse its req_ready for one cycle (the accept cycle), combinationally from the registered state.
  - Latch a, b, func and the grant id into internal registers.
  - Both valid: grant the requester ≠ rr pointer's last winner. Pointer toggles to favour the loser next time.
  - Single valid: grant it regardless of pointer.
  - Illegal func (> MAX_FUNC): go directly to RESP with err=1, data=0. No ALU activity.
  - Legal func: go to LOAD.
- LOAD: drive alu_a/alu_b from latched operands; alu_enable=0; go to EXEC.
- EXEC:
  - Hold operands; drive alu_func; alu_enable=1 for exactly this cycle; go to WAIT.
  - alu_a, alu_b, alu_func stay stable from LOAD through WAIT.
- WAIT:
  - On alu_out_valid=1, capture alu_out into the granted rsp_data; go to RESP.
  - Watchdog: 4-cycle counter from entering WAIT. If alu_out_valid is not seen, go to RESP with err=1, data=0.
- RESP:
  - Assert granted rsp_valid with rsp_data/rsp_err stable until rsp_ready=1.
  - Handshake cycle: clear rsp_valid/err, go to IDLE.
  - The non-granted rsp_valid stays 0.
- Latency: accept edge → rsp_valid is 4 cycles for a legal op (LOAD, EXEC, WAIT×2, capture). Illegal func → rsp_valid 1 cycle after accept.
- No new request is accepted until RESP completes. req_ready is 0 in every state except the IDLE grant cycle. A requester deasserting valid while not granted is legal.
- alu_enable is never asserted outside EXEC; never two pulses per operation.
- Reset mid-operation (any state): immediate return to reset values. The in-flight result is discarded; no response is produced.
- busy = 1 in LOAD, EXEC, WAIT, RESP.

Test Plan:
- Single op: req0 a=8'd200, b=8'd100, func=0 → one alu_enable pulse; rsp0_valid with rsp0_data=16'd300, err=0, 4 cycles after accept; rsp1_valid stays 0.
- Contention: req0 and req1 both valid from reset (req0 func=2, 12×12; req1 func=1, 9−4).
  - req0 granted first → rsp0_data=144.
  - Then req1 → rsp1_data=5.
  - Repeat both → order alternates (req1 first).
- Illegal func: req1 func=4'd14 → rsp1_valid 1 cycle after accept, rsp1_err=1, data=0; alu_enable never asserted.
- Response backpressure: rsp0_ready held 0 for 10 cycles → rsp0_valid/data stable, req0_ready and req1_ready stay 0, alu_enable stays 0. Ready=1 → back to IDLE next cycle.
- Watchdog: model ALU with alu_out_valid stuck 0 → rsp_err=1 exactly 4 cycles after entering WAIT; busy drops after handshake.
- Reset mid-op: RST=1 during WAIT → all outputs 0 asynchronously. After release, a fresh req0 (func=8, 0xF0^0x3C) returns 16'h00CC.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered ALU between two valid/ready requesters with
// round-robin arbitration, one operation in flight, and results routed to the grantee.
module alu_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int FUNC_WIDTH = 4,
    parameter int MAX_FUNC   = 13
) (
    input  logic                      CLK,
    input  logic                      RST,

    input  logic                      req0_valid,
    output logic                      req0_ready,
    input  logic [DATA_WIDTH-1:0]     req0_a,
    input  logic [DATA_WIDTH-1:0]     req0_b,
    input  logic [FUNC_WIDTH-1:0]     req0_func,
    output logic                      rsp0_valid,
    input  logic                      rsp0_ready,
    output logic [2*DATA_WIDTH-1:0]   rsp0_data,
    output logic                      rsp0_err,

    input  logic                      req1_valid,
    output logic                      req1_ready,
    input  logic [DATA_WIDTH-1:0]     req1_a,
    input  logic [DATA_WIDTH-1:0]     req1_b,
    input  logic [FUNC_WIDTH-1:0]     req1_func,
    output logic                      rsp1_valid,
    input  logic                      rsp1_ready,
    output logic [2*DATA_WIDTH-1:0]   rsp1_data,
    output logic                      rsp1_err,

    output logic [DATA_WIDTH-1:0]     alu_a,
    output logic [DATA_WIDTH-1:0]     alu_b,
    output logic [FUNC_WIDTH-1:0]     alu_func,
    output logic                      alu_enable,
    input  logic [2*DATA_WIDTH-1:0]   alu_out,
    input  logic                      alu_out_valid,

    output logic                      busy
);

    localparam logic [31:0] MAX_FUNC_U = MAX_FUNC;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EXEC,
        WAIT,
        RESP
    } state_t;

    state_t                  state;
    logic                    rr_ptr;
    logic                    gnt_id;
    logic [1:0]              wd_cnt;

    logic                    any_req;
    logic                    pick1;
    logic [DATA_WIDTH-1:0]   sel_a;
    logic [DATA_WIDTH-1:0]   sel_b;
    logic [FUNC_WIDTH-1:0]   sel_func;
    logic                    gnt_rsp_valid;
    logic                    gnt_rsp_ready;

    function automatic logic func_illegal(input logic [FUNC_WIDTH-1:0] f);
        return {{(32-FUNC_WIDTH){1'b0}}, f} > MAX_FUNC_U;
    endfunction

    // rr_ptr names the favoured requester; it only moves when both contend.
    always_comb begin
        any_req       = req0_valid | req1_valid;
        pick1         = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
        sel_a         = pick1 ? req1_a    : req0_a;
        sel_b         = pick1 ? req1_b    : req0_b;
        sel_func      = pick1 ? req1_func : req0_func;
        gnt_rsp_valid = gnt_id ? rsp1_valid : rsp0_valid;
        gnt_rsp_ready = gnt_id ? rsp1_ready : rsp0_ready;
    end

    assign req0_ready = !RST && (state == IDLE) && any_req && !pick1;
    assign req1_ready = !RST && (state == IDLE) && any_req &&  pick1;
    assign busy       = (state != IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            rr_ptr     <= 1'b0;
            gnt_id     <= 1'b0;
            wd_cnt     <= 2'd0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_func   <= '0;
            alu_enable <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp0_err   <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_data  <= '0;
            rsp1_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt_id <= pick1;
                        if (req0_valid && req1_valid) begin
                            rr_ptr <= ~pick1;
                        end
                        // Illegal codes never touch the ALU pins.
                        if (func_illegal(sel_func)) begin
                            state <= RESP;
                        end else begin
                            alu_a    <= sel_a;
                            alu_b    <= sel_b;
                            alu_func <= sel_func;
                            state    <= LOAD;
                        end
                    end
                end

                LOAD: begin
                    alu_enable <= 1'b1;
                    state      <= EXEC;
                end

                EXEC: begin
                    alu_enable <= 1'b0;
                    wd_cnt     <= 2'd0;
                    state      <= WAIT;
                end

                WAIT: begin
                    if (alu_out_valid || (wd_cnt == 2'd3)) begin
                        if (gnt_id) begin
                            rsp1_valid <= 1'b1;
                            rsp1_err   <= ~alu_out_valid;
                            rsp1_data  <= alu_out_valid ? alu_out : '0;
                        end else begin
                            rsp0_valid <= 1'b1;
                            rsp0_err   <= ~alu_out_valid;
                            rsp0_data  <= alu_out_valid ? alu_out : '0;
                        end
                        alu_a    <= '0;
                        alu_b    <= '0;
                        alu_func <= '0;
                        state    <= RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 2'd1;
                    end
                end

                RESP: begin
                    // Arriving here without a pending response means an illegal code.
                    if (!gnt_rsp_valid) begin
                        if (gnt_id) begin
                            rsp1_valid <= 1'b1;
                            rsp1_err   <= 1'b1;
                            rsp1_data  <= '0;
                        end else begin
                            rsp0_valid <= 1'b1;
                            rsp0_err   <= 1'b1;
                            rsp0_data  <= '0;
                        end
                    end else if (gnt_rsp_ready) begin
                        rsp0_valid <= 1'b0;
                        rsp0_err   <= 1'b0;
                        rsp0_data  <= '0;
                        rsp1_valid <= 1'b0;
                        rsp1_err   <= 1'b0;
                        rsp1_data  <= '0;
                        state      <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed plus randomized checks of alu_arbiter against a
// transaction-level model of arbitration, ALU results, errors and latency.
module tb_alu_arbiter;

    localparam int MAXF = 13;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]  req0_func = '0, req1_func = '0;
    logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
    logic [15:0] rsp0_data, rsp1_data;
    logic [7:0]  alu_a, alu_b;
    logic [3:0]  alu_func;
    logic        alu_enable;
    logic [15:0] alu_out;
    logic        alu_out_valid;
    logic        busy;

    logic        alu_stuck = 1'b0;
    logic        alu_stage;
    int          en_cnt = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          favour = 0;
    int          last_w = -1;
    logic [15:0] last_data = '0;

    always #5 CLK = ~CLK;

    alu_arbiter dut (
        .CLK(CLK), .RST(RST),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_func(req0_func), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_func(req1_func), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_enable(alu_enable),
        .alu_out(alu_out), .alu_out_valid(alu_out_valid), .busy(busy)
    );

    function automatic logic [15:0] ref_alu(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] xa, xb;
        xa = {8'h00, a};
        xb = {8'h00, b};
        case (f)
            4'd0:    return xa + xb;
            4'd1:    return xa - xb;
            4'd2:    return xa * xb;
            4'd3:    return xa & xb;
            4'd4:    return xa | xb;
            4'd8:    return xa ^ xb;
            default: return {a, b};
        endcase
    endfunction

    // External ALU: enable sampled on one edge, result valid for one cycle after the next.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            alu_stage     <= 1'b0;
            alu_out_valid <= 1'b0;
            alu_out       <= '0;
        end else begin
            alu_stage     <= alu_enable;
            alu_out_valid <= alu_stage && !alu_stuck;
            alu_out       <= alu_stage ? ref_alu(alu_func, alu_a, alu_b) : 16'h0000;
        end
    end

    always @(negedge CLK) if (alu_enable) en_cnt <= en_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, {24'h0, req0_ready, req1_ready, rsp0_valid, rsp1_valid,
                               rsp0_err, rsp1_err, alu_enable, busy}, 32'h0);
        check({tag, "_rspdata"}, {rsp0_data, rsp1_data}, 32'h0);
        check({tag, "_alupins"}, {12'h0, alu_a, alu_b, alu_func}, 32'h0);
    endtask

    // Response the specification promises for the winner's current request.
    task automatic expect_rsp(input int w, output logic [15:0] d, output logic e, output int lat);
        logic [3:0] f;
        logic [7:0] a, b;
        f = (w == 1) ? req1_func : req0_func;
        a = (w == 1) ? req1_a    : req0_a;
        b = (w == 1) ? req1_b    : req0_b;
        if (int'(f) > MAXF) begin
            d = 16'h0; e = 1'b1; lat = 1;
        end else if (alu_stuck) begin
            d = 16'h0; e = 1'b1; lat = 2 + 4;
        end else begin
            d = ref_alu(f, a, b); e = 1'b0; lat = 4;
        end
    endtask

    // Called at a falling edge with requests already driven; serves exactly one grant.
    task automatic serve(input int bp);
        int exp_w, got_w, lat, exp_lat, en0, bad;
        logic [15:0] exp_d, d0;
        logic exp_e;
        if (req0_valid && req1_valid) begin
            exp_w  = favour;
            favour = 1 - favour;
        end else begin
            exp_w = req1_valid ? 1 : 0;
        end
        expect_rsp(exp_w, exp_d, exp_e, exp_lat);
        got_w = -1;
        for (int i = 0; i < 16 && got_w < 0; i++) begin
            #1;
            if (req0_ready && !req1_ready)      got_w = 0;
            else if (req1_ready && !req0_ready) got_w = 1;
            else if (req0_ready)                got_w = 2;
            if (got_w < 0) @(negedge CLK);
        end
        check("grant", got_w, exp_w);
        last_w = got_w;
        if (got_w != exp_w) return;
        en0 = en_cnt;
        @(posedge CLK);
        @(negedge CLK);
        if (exp_w == 1) req1_valid = 1'b0; else req0_valid = 1'b0;
        lat = 0;
        bad = 0;
        while (!((exp_w == 1) ? rsp1_valid : rsp0_valid) && lat < 12) begin
            if (req0_ready || req1_ready || !busy || ((exp_w == 1) ? rsp0_valid : rsp1_valid)) bad++;
            @(negedge CLK);
            lat++;
        end
        check("latency", lat, exp_lat);
        check("quiet_while_busy", bad, 0);
        check("rsp_data", (exp_w == 1) ? rsp1_data : rsp0_data, exp_d);
        check("rsp_err", (exp_w == 1) ? rsp1_err : rsp0_err, exp_e);
        check("other_rsp_idle", (exp_w == 1) ? rsp0_valid : rsp1_valid, 0);
        check("alu_enable_pulses", en_cnt - en0, (exp_lat == 1) ? 0 : 1);
        last_data = (exp_w == 1) ? rsp1_data : rsp0_data;
        d0 = last_data;
        bad = 0;
        for (int i = 0; i < bp; i++) begin
            @(negedge CLK);
            if (!((exp_w == 1) ? rsp1_valid : rsp0_valid) || (((exp_w == 1) ? rsp1_data : rsp0_data) !== d0) ||
                (((exp_w == 1) ? rsp1_err : rsp0_err) !== exp_e) || req0_ready || req1_ready || alu_enable ||
                ((exp_w == 1) ? rsp0_valid : rsp1_valid)) bad++;
        end
        check("hold_under_backpressure", bad, 0);
        if (exp_w == 1) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        @(negedge CLK);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        check("valid_cleared", (exp_w == 1) ? rsp1_valid : rsp0_valid, 0);
        check("idle_after_handshake", busy, 0);
    endtask

    initial begin
        int bad;
        #1;
        check_all_zero("por");
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        #1;
        check_all_zero("after_release");
        @(negedge CLK);

        // Single operation on requester 0.
        req0_a = 8'd200; req0_b = 8'd100; req0_func = 4'd0; req0_valid = 1'b1;
        serve(0);
        check("single_add_300", last_data, 16'd300);

        // Contention, then alternation.
        req0_a = 8'd12; req0_b = 8'd12; req0_func = 4'd2; req0_valid = 1'b1;
        req1_a = 8'd9;  req1_b = 8'd4;  req1_func = 4'd1; req1_valid = 1'b1;
        serve(0);
        check("contend_first_req0", last_w, 0);
        check("mul_144", last_data, 16'd144);
        serve(0);
        check("then_req1", last_w, 1);
        check("sub_5", last_data, 16'd5);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        serve(0);
        check("alternate_req1_first", last_w, 1);
        serve(0);
        check("alternate_req0_second", last_w, 0);

        // Illegal function code.
        req1_a = 8'h55; req1_b = 8'hAA; req1_func = 4'd14; req1_valid = 1'b1;
        serve(2);
        check("illegal_err", rsp1_err, 0);

        // Response backpressure with the other requester waiting.
        req0_a = 8'd7; req0_b = 8'd5; req0_func = 4'd4; req0_valid = 1'b1;
        req1_a = 8'd3; req1_b = 8'd6; req1_func = 4'd3; req1_valid = 1'b1;
        serve(10);
        serve(0);

        // Watchdog on a silent ALU.
        alu_stuck = 1'b1;
        req0_a = 8'd1; req0_b = 8'd2; req0_func = 4'd0; req0_valid = 1'b1;
        serve(1);
        alu_stuck = 1'b0;

        // Asynchronous reset in the middle of an operation.
        req0_a = 8'h11; req0_b = 8'h22; req0_func = 4'd0; req0_valid = 1'b1;
        #1;
        check("midop_ready", req0_ready, 1);
        @(posedge CLK);
        @(negedge CLK);
        req0_valid = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check("midop_busy", busy, 1);
        #2 RST = 1'b1;
        #1;
        check_all_zero("async_reset");
        favour = 0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (rsp0_valid || rsp1_valid || busy || alu_enable) bad++;
        end
        check("no_rsp_after_reset", bad, 0);
        req0_a = 8'hF0; req0_b = 8'h3C; req0_func = 4'd8; req0_valid = 1'b1;
        serve(1);
        check("xor_00cc", last_data, 16'h00CC);

        // Randomized traffic against the model.
        for (int it = 0; it < 40; it++) begin
            if (!req0_valid && $urandom_range(0, 1) == 1) begin
                req0_a = 8'($urandom); req0_b = 8'($urandom);
                req0_func = 4'($urandom_range(0, 15)); req0_valid = 1'b1;
            end
            if (!req1_valid && $urandom_range(0, 1) == 1) begin
                req1_a = 8'($urandom); req1_b = 8'($urandom);
                req1_func = 4'($urandom_range(0, 15)); req1_valid = 1'b1;
            end
            if (!req0_valid && !req1_valid) begin
                req0_a = 8'($urandom); req0_b = 8'($urandom);
                req0_func = 4'($urandom_range(0, 15)); req0_valid = 1'b1;
            end
            alu_stuck = ($urandom_range(0, 7) == 0);
            serve($urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
